// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the single-cycle core: halt, debounced single-step,
// divided free-run and a PC breakpoint, all expressed as one-cycle cpu_en pulses.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 100_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_step_btn,
    input  logic        i_run_sw,
    input  logic        i_bp_enable,
    input  logic [31:0] i_bp_addr,
    input  logic [31:0] i_pc,
    output logic        o_cpu_en,
    output logic        o_halted,
    output logic        o_bp_hit,
    output logic [1:0]  o_state,
    output logic [31:0] o_instr_count
);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = 27;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_STEP  = 2'b01,
        S_RUN   = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    logic             r_step_s1, r_step_s2;
    logic             r_run_s1, r_run_s2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_step_stable, r_step_stable_d;
    logic             r_step_req;
    logic [DIV_W-1:0] r_div;
    logic             r_cpu_en, r_halted, r_bp_hit;
    logic [31:0]      r_instr_count;
    state_t           r_state, w_next_state;
    logic             w_pulse_due, w_bp_match, w_run_pulse;
    logic             w_cpu_en_d, w_halted_d, w_bp_hit_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
        end else begin
            r_step_s1 <= i_step_btn;
            r_step_s2 <= r_step_s1;
            r_run_s1  <= i_run_sw;
            r_run_s2  <= r_run_s1;
        end
    end

    // Stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_db_cnt        <= '0;
            r_step_stable   <= 1'b0;
            r_step_stable_d <= 1'b0;
            r_step_req      <= 1'b0;
        end else begin
            r_step_stable_d <= r_step_stable;
            r_step_req      <= r_step_stable & ~r_step_stable_d;
            if (r_step_s2 == r_step_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_step_stable <= r_step_s2;
                r_db_cnt      <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_HALT;
        else         r_state <= w_next_state;
    end

    assign w_pulse_due = (r_div == DIV_LAST);
    assign w_bp_match  = i_bp_enable && (i_pc == i_bp_addr);

    // Dropping run_sw outranks a due pulse; in BREAK a step request outranks it.
    always_comb begin
        w_next_state = r_state;
        w_run_pulse  = 1'b0;
        case (r_state)
            S_HALT: begin
                if (r_run_s2)        w_next_state = S_RUN;
                else if (r_step_req) w_next_state = S_STEP;
            end
            S_STEP: w_next_state = S_HALT;
            S_RUN: begin
                if (!r_run_s2) begin
                    w_next_state = S_HALT;
                end else if (w_pulse_due) begin
                    if (w_bp_match) w_next_state = S_BREAK;
                    else            w_run_pulse  = 1'b1;
                end
            end
            S_BREAK: begin
                if (r_step_req)     w_next_state = S_STEP;
                else if (!r_run_s2) w_next_state = S_HALT;
            end
            default: w_next_state = S_HALT;
        endcase
    end

    always_comb begin
        w_cpu_en_d = (w_next_state == S_STEP) || w_run_pulse;
        w_halted_d = (w_next_state == S_HALT) || (w_next_state == S_BREAK);
        w_bp_hit_d = (w_next_state == S_BREAK);
    end

    // Divider only advances while staying in RUN; any exit restarts the period.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_en      <= 1'b0;
            r_halted      <= 1'b1;
            r_bp_hit      <= 1'b0;
            r_div         <= '0;
            r_instr_count <= '0;
        end else begin
            r_cpu_en      <= w_cpu_en_d;
            r_halted      <= w_halted_d;
            r_bp_hit      <= w_bp_hit_d;
            r_instr_count <= r_instr_count + {31'b0, r_cpu_en};
            if ((r_state == S_RUN) && (w_next_state == S_RUN) && !w_pulse_due)
                r_div <= r_div + DIV_W'(1);
            else
                r_div <= '0;
        end
    end

    assign o_cpu_en      = r_cpu_en;
    assign o_halted      = r_halted;
    assign o_bp_hit      = r_bp_hit;
    assign o_state       = r_state;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: stimulus queues each expected cpu_en
// pulse (cycle, count, state); a negedge monitor pops and checks every pulse.
module tb_cpu_step_controller;
    localparam int DEB = 4;
    localparam int DIV = 5;
    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_STEP  = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    logic        clk = 1'b0;
    logic        reset, step_btn, run_sw, bp_enable;
    logic [31:0] bp_addr;
    logic [31:0] pc = '0;
    logic        cpu_en, halted, bp_hit;
    logic [1:0]  state;
    logic [31:0] instr_count;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    logic prev_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic [1:0]  st;
    } exp_t;
    exp_t exp_q[$];

    cpu_step_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_step_btn   (step_btn),
        .i_run_sw     (run_sw),
        .i_bp_enable  (bp_enable),
        .i_bp_addr    (bp_addr),
        .i_pc         (pc),
        .o_cpu_en     (cpu_en),
        .o_halted     (halted),
        .o_bp_hit     (bp_hit),
        .o_state      (state),
        .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: PC advances by one instruction per enable pulse.
    always @(posedge clk) begin
        if (reset)       pc <= '0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [31:0] n, input logic [1:0] s);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        e.st  = s;
        exp_q.push_back(e);
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_en"}, {31'b0, cpu_en}, 32'd0);
        check({tag, "_state"},  {30'b0, state}, 32'(ST_HALT));
        check({tag, "_halted"}, {31'b0, halted}, 32'd1);
        check({tag, "_bp_hit"}, {31'b0, bp_hit}, 32'd0);
        check({tag, "_count"},  instr_count, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_en) begin
            check("no_back_to_back", {31'b0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pulse: cpu_en high at cycle %0d, required low", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_count", instr_count, e.cnt);
                check("pulse_state", {30'b0, state}, {30'b0, e.st});
            end
        end
        prev_en = cpu_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, t, u, v, w, x, p, y;
        reset = 1'b1; step_btn = 1'b1; run_sw = 1'b1; bp_enable = 1'b0; bp_addr = '0;

        // Reset held with both inputs active
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals("reset");
        end
        reset = 1'b0; step_btn = 1'b0; r = cyc;
        tick_to(r + 2); check("pre_run_state", {30'b0, state}, 32'(ST_HALT));
        tick_to(r + 3); check("run_entry_state", {30'b0, state}, 32'(ST_RUN));
        check("run_entry_halted", {31'b0, halted}, 32'd0);
        run_sw = 1'b0;
        tick_to(r + 6); check("run_abort_state", {30'b0, state}, 32'(ST_HALT));

        // Bouncy press: one pulse once the level has been stable for DEB cycles
        t = cyc;
        expect_pulse(t + 10, 32'd0, ST_STEP);
        step_btn = 1'b1; tick_to(t + 1);
        step_btn = 1'b0; tick_to(t + 2);
        step_btn = 1'b1; tick_to(t + 12);
        step_btn = 1'b0; tick_to(t + 26);
        check("step1_count", instr_count, 32'd1);
        check("step1_state", {30'b0, state}, 32'(ST_HALT));

        u = cyc;
        expect_pulse(u + 8, 32'd1, ST_STEP);
        step_btn = 1'b1; tick_to(u + 10);
        step_btn = 1'b0; tick_to(u + 24);
        check("step2_count", instr_count, 32'd2);

        // Free run for 52 cycles: pulses every DIV cycles from entry + DIV
        v = cyc;
        for (int k = 0; k < 10; k++) expect_pulse(v + 8 + 5 * k, 32'(2 + k), ST_RUN);
        run_sw = 1'b1; tick_to(v + 52);
        run_sw = 1'b0; tick_to(v + 58);
        check("run_stop_state", {30'b0, state}, 32'(ST_HALT));
        check("run_count", instr_count, 32'd12);
        tick_to(v + 62);

        // Breakpoint at 0xC
        reset = 1'b1; tick_to(cyc + 1);
        check_reset_vals("reset2");
        reset = 1'b0; bp_enable = 1'b1; bp_addr = 32'h0000_000C; run_sw = 1'b1; w = cyc;
        expect_pulse(w + 8,  32'd0, ST_RUN);
        expect_pulse(w + 13, 32'd1, ST_RUN);
        expect_pulse(w + 18, 32'd2, ST_RUN);
        tick_to(w + 22); check("pre_break_state", {30'b0, state}, 32'(ST_RUN));
        tick_to(w + 23);
        check("break_state",  {30'b0, state}, 32'(ST_BREAK));
        check("break_bp_hit", {31'b0, bp_hit}, 32'd1);
        check("break_halted", {31'b0, halted}, 32'd1);
        check("break_count",  instr_count, 32'd3);
        tick_to(w + 30); check("break_hold_state", {30'b0, state}, 32'(ST_BREAK));

        // Step out of BREAK, then RUN resumes from pc 0x10 until the next breakpoint
        x = cyc;
        expect_pulse(x + 8,  32'd3, ST_STEP);
        expect_pulse(x + 15, 32'd4, ST_RUN);
        expect_pulse(x + 20, 32'd5, ST_RUN);
        step_btn = 1'b1;
        tick_to(x + 9);
        check("after_step_state",  {30'b0, state}, 32'(ST_HALT));
        check("after_step_bp_hit", {31'b0, bp_hit}, 32'd0);
        tick_to(x + 10);
        check("continue_state", {30'b0, state}, 32'(ST_RUN));
        step_btn = 1'b0; bp_addr = 32'h0000_0018;
        tick_to(x + 25);
        check("break2_state", {30'b0, state}, 32'(ST_BREAK));
        check("break2_count", instr_count, 32'd6);

        // step_req and run_sw_s fall together in BREAK: STEP wins, then HALT
        p = cyc;
        expect_pulse(p + 8, 32'd6, ST_STEP);
        step_btn = 1'b1; tick_to(p + 5);
        run_sw = 1'b0; tick_to(p + 9);
        check("simul_state",  {30'b0, state}, 32'(ST_HALT));
        check("simul_halted", {31'b0, halted}, 32'd1);
        check("simul_bp_hit", {31'b0, bp_hit}, 32'd0);
        step_btn = 1'b0; tick_to(p + 20);
        check("simul_count", instr_count, 32'd7);
        check("simul_hold_state", {30'b0, state}, 32'(ST_HALT));

        // Reset on the cycle the divider sits at DIV-1
        y = cyc;
        bp_enable = 1'b0;
        run_sw = 1'b1; tick_to(y + 7);
        reset = 1'b1; tick_to(y + 8);
        check_reset_vals("midrun_reset");
        reset = 1'b0; run_sw = 1'b0; tick_to(y + 20);
        check("post_reset_state", {30'b0, state}, 32'(ST_HALT));
        check("post_reset_count", instr_count, 32'd0);

        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sequences execution of the single-cycle MIPS core by generating a one-cycle clock-enable pulse (`cpu_en`) in the `clk` domain.
- Replaces a free-running divided clock: the core, data memory and PC register run on `clk`, gated by `cpu_en`.
- Supports halt, debounced single-step, free-run at a programmable rate, and a PC breakpoint.
- Status outputs feed the seven-segment selector and board LEDs.

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before the step button level is accepted (10 ms at 100 MHz).
- `RUN_DIV`, default 100_000_000: `clk` cycles per `cpu_en` pulse in RUN; legal range 2 to 2^27-1.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high; all state is cleared on the clk edge where `reset`=1.
- `step_btn`  in  1  raw asynchronous push button.
- `run_sw`  in  1  raw asynchronous slide switch; 1 = run.
- `bp_enable`  in  1  breakpoint enable, treated as quasi-static.
- `bp_addr`  in  32  breakpoint PC, treated as quasi-static.
- `pc`  in  32  current PC from the core.
- `cpu_en`  out  1  registered one-cycle enable to the core and memories.
- `halted`  out  1  1 in HALT or BREAK.
- `bp_hit`  out  1  1 while in BREAK.
- `state`  out  2  encoding: HALT=00, STEP=01, RUN=10, BREAK=11.
- `instr_count`  out  32  number of `cpu_en` pulses issued.

Behaviour:
- Reset values: `state`=HALT, `cpu_en`=0, `halted`=1, `bp_hit`=0, `instr_count`=0. Synchronizer flops, debounce counter, stable level and divider counter are all cleared to 0. Reset asserted mid-RUN or mid-STEP aborts on that edge; no `cpu_en` is issued in the reset cycle.
- Input conditioning:
  - `step_btn` and `run_sw` each pass through a 2-flop synchronizer.
  - Step debounce: the counter increments while the synced value differs from the stable level and clears when they match. When the count reaches `DEBOUNCE_CYCLES`-1 and still differs, the stable level is updated and the counter cleared.
  - `step_req` is a one-cycle pulse on a 0->1 transition of the stable level.
  - `run_sw` is synchronized only, not debounced.
- FSM, one transition per `clk` edge:
  - HALT: if `run_sw_s`=1, go to RUN with the divider cleared. Else if `step_req`, go to STEP. Otherwise stay.
  - STEP: `cpu_en`=1 for exactly this one cycle, then HALT unconditionally. `step_req` seen while in STEP is dropped.
  - RUN:
    - The divider counts 0..`RUN_DIV`-1 and wraps.
    - On the cycle the divider is at `RUN_DIV`-1, a pulse is due:
      - If `bp_enable`=1 and `pc`==`bp_addr`, the pulse is suppressed and the next state is BREAK.
      - Otherwise `cpu_en`=1 the following cycle.
    - `run_sw_s`=0 goes to HALT, clears the divider, and cancels any pulse not yet issued.
    - `step_req` is ignored in RUN.
  - BREAK: `cpu_en`=0, `bp_hit`=1.
    - `step_req` goes to STEP, which executes the breakpoint instruction.
    - `run_sw_s`=0 goes to HALT.
    - If both occur in the same cycle, STEP wins.
    - After the STEP, HALT with `run_sw_s`=1 re-enters RUN (continue). PC has advanced, so there is no immediate re-hit.
- Latency:
  - `step_req` at edge N gives `state`=STEP at N+1, with `cpu_en` high during the cycle after N+1 only.
  - End to end, from raw button to `cpu_en`: 2 sync + `DEBOUNCE_CYCLES` + 2 cycles.
  - In RUN, the first pulse occurs `RUN_DIV` cycles after entry, then every `RUN_DIV` cycles.
- `cpu_en` is always a single-cycle pulse. Two consecutive high cycles are illegal.
- `instr_count` increments on every cycle with `cpu_en`=1 and wraps from 0xFFFF_FFFF to 0.
- `halted` and `bp_hit` are registered and decoded from the next state, so they change on the same edge as `state`.
- The breakpoint compares the full 32-bit `pc`. A breakpoint at the PC present on entry to RUN is honoured at the first due pulse.

Test Plan (`DEBOUNCE_CYCLES`=4, `RUN_DIV`=5):
- Reset: hold `reset` 3 cycles with `step_btn`=1 and `run_sw`=1. Required: `cpu_en`=0, `state`=00, `halted`=1, `instr_count`=0 throughout. After release, `state` reaches RUN 3 cycles after the first non-reset edge.
- Step and bounce: toggle `step_btn` 1/0/1 at 1-cycle spacing, then hold 1 for 10 cycles. Required: exactly one `cpu_en` pulse and `instr_count`=1. Releasing and re-pressing cleanly yields `instr_count`=2.
- Run rate: set `run_sw`=1 for 52 cycles. Required: `cpu_en` every 5th cycle, no back-to-back highs, 9 or 10 pulses counted exactly against the model. Dropping `run_sw` produces no further pulses within 3 cycles.
- Breakpoint: `bp_enable`=1, `bp_addr`=0x0000_000C, with the model `pc` advancing by 4 per pulse from 0. Required: pulses at pc 0, 4 and 8, then `state`=11, `bp_hit`=1, `instr_count`=3. A step gives `instr_count`=4, and the run continues with pc 0x10 onwards.
- Simultaneous events in BREAK: `step_req` and `run_sw` fall in the same cycle. Required: STEP then HALT, with one pulse.
- Reset mid-RUN: assert `reset` on the cycle the divider is at 4. Required: no `cpu_en` pulse, all outputs back to reset values.
